// File: rtl/fifo_apb_pkg.sv
// Shared state type, address decode constants and eligibility helper for the FIFO APB arbiter.
package fifo_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int          NUM_REQ         = 2;
  localparam int          FIFO_DATA_BIT   = 31;
  localparam logic [31:0] DEPTH_REG       = 32'h0000_0000;
  localparam int          DEFAULT_TIMEOUT = 16;

  // FIFO-data accesses wait on the matching flag; register accesses are never held back.
  function automatic logic is_eligible(input logic req, input logic write,
                                       input logic fifo_sel, input logic full,
                                       input logic empty);
    return req && !(fifo_sel && write && full) && !(fifo_sel && !write && empty);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from an eligible vector, pointer moves past the winner on accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] eligible,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (ptr) begin
      grant[1] = eligible[1];
      grant[0] = eligible[0] & ~eligible[1];
    end else begin
      grant[0] = eligible[0];
      grant[1] = eligible[1] & ~eligible[0];
    end
  end

  // After serving requester 0 the pointer favours 1, and vice versa.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (accept && (grant != 2'b00)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/fifo_apb_arbiter.sv
// Two requesters sharing one FIFO APB completer through a round-robin APB master.
// Define APB_ARB_TIMEOUT_EN to end ACCESS with an error after TIMEOUT cycles without PREADY.
module fifo_apb_arbiter
  import fifo_apb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [1:0]       req_i,
  input  logic [1:0]       req_write_i,
  input  logic [1:0][31:0] req_addr_i,
  input  logic [1:0][31:0] req_wdata_i,
  input  logic [1:0][3:0]  req_strb_i,
  output logic [1:0]       done_o,
  output logic [31:0]      rdata_o,
  output logic             err_o,
  output logic             PSEL,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [31:0]      PADDR,
  output logic [31:0]      PWDATA,
  output logic [3:0]       PSTRB,
  output logic [2:0]       PPROT,
  input  logic             PREADY,
  input  logic [31:0]      PRDATA,
  input  logic             PSLVERR,
  input  logic             fifo_full_i,
  input  logic             fifo_empty_i
);

  apb_state_t state;
  logic       gnt_idx;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic       accept;
  logic       finish;
  logic       timed_out;
  logic       unused_cfg;

  always_comb begin
    eligible = 2'b00;
    for (int i = 0; i < 2; i++) begin
      eligible[i] = is_eligible(req_i[i], req_write_i[i], req_addr_i[i][FIFO_DATA_BIT],
                                fifo_full_i, fifo_empty_i);
    end
  end

  assign accept = (state == IDLE);

  rr_arb2 u_arb (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .eligible (eligible),
    .accept   (accept),
    .grant    (grant)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counts ACCESS cycles already spent without PREADY; fires on the TIMEOUT-th.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
    end else if ((state != ACCESS) || PREADY) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timed_out = (state == ACCESS) && !PREADY && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  assign unused_cfg = (NREQ != NUM_REQ) | (DEPTH_REG != 32'h0) | (TIMEOUT < 1);

  // The request is captured at grant so requesters may change or drop inputs mid-transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PSTRB   <= '0;
      gnt_idx <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            state   <= SETUP;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            gnt_idx <= grant[1];
            PWRITE  <= req_write_i[grant[1]];
            PADDR   <= req_addr_i[grant[1]];
            PWDATA  <= req_wdata_i[grant[1]];
            PSTRB   <= req_strb_i[grant[1]];
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (finish) begin
            state   <= IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

  // Completion is reported in the finishing ACCESS cycle so the requester can drop req before the next IDLE.
  assign finish  = (state == ACCESS) && (PREADY || timed_out);
  assign done_o  = finish ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  assign rdata_o = (finish && PREADY && !PWRITE) ? PRDATA : 32'h0;
  assign err_o   = finish && ((PREADY && PSLVERR) || timed_out);
  assign PPROT   = 3'b000;

endmodule

// File: tb/tb_fifo_apb_arbiter.sv
// Directed, table-driven bench for fifo_apb_arbiter (default build, timeout feature off).
module tb_fifo_apb_arbiter;

  localparam logic        H   = 1'b1;
  localparam logic        L   = 1'b0;
  localparam logic [31:0] FA  = 32'h8000_0000;
  localparam logic [31:0] RA  = 32'h0000_0100;
  localparam logic [31:0] WD0 = 32'h0000_0002;
  localparam logic [31:0] WD1 = 32'hB1B1_0001;

  logic             PCLK = 1'b0;
  logic             PRESETn;
  logic [1:0]       req_i;
  logic [1:0]       req_write_i;
  logic [1:0][31:0] req_addr_i;
  logic [1:0][31:0] req_wdata_i;
  logic [1:0][3:0]  req_strb_i;
  logic [1:0]       done_o;
  logic [31:0]      rdata_o;
  logic             err_o;
  logic             PSEL;
  logic             PENABLE;
  logic             PWRITE;
  logic [31:0]      PADDR;
  logic [31:0]      PWDATA;
  logic [3:0]       PSTRB;
  logic [2:0]       PPROT;
  logic             PREADY;
  logic [31:0]      PRDATA;
  logic             PSLVERR;
  logic             fifo_full_i;
  logic             fifo_empty_i;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    string       name;
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        full;
    logic        empty;
    logic        ready;
    logic        slverr;
    logic [31:0] prdata;
    logic        psel;
    logic        pen;
    logic        pw;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [1:0]  done;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  fifo_apb_arbiter #(.NREQ(2), .TIMEOUT(16)) dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .req_i        (req_i),
    .req_write_i  (req_write_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_strb_i   (req_strb_i),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PWRITE       (PWRITE),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PSTRB        (PSTRB),
    .PPROT        (PPROT),
    .PREADY       (PREADY),
    .PRDATA       (PRDATA),
    .PSLVERR      (PSLVERR),
    .fifo_full_i  (fifo_full_i),
    .fifo_empty_i (fifo_empty_i)
  );

  always #5 PCLK = ~PCLK;

  function automatic vec_t mk(input string n, input logic [1:0] req, input logic [1:0] wr,
                              input logic [31:0] a0, input logic [31:0] a1, input logic full,
                              input logic empty, input logic ready, input logic slverr,
                              input logic [31:0] prdata, input logic psel, input logic pen,
                              input logic pw, input logic [31:0] paddr, input logic [31:0] pwdata,
                              input logic [1:0] done, input logic [31:0] rdata, input logic err);
    vec_t v;
    v.name = n;  v.req = req;  v.wr = wr;  v.a0 = a0;  v.a1 = a1;
    v.full = full;  v.empty = empty;  v.ready = ready;  v.slverr = slverr;  v.prdata = prdata;
    v.psel = psel;  v.pen = pen;  v.pw = pw;  v.paddr = paddr;  v.pwdata = pwdata;
    v.done = done;  v.rdata = rdata;  v.err = err;
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    req_i         = v.req;
    req_write_i   = v.wr;
    req_addr_i[0] = v.a0;
    req_addr_i[1] = v.a1;
    fifo_full_i   = v.full;
    fifo_empty_i  = v.empty;
    PREADY        = v.ready;
    PSLVERR       = v.slverr;
    PRDATA        = v.prdata;
  endtask

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    check_count++;
    if (act === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Round robin from reset: both requesters write FIFO data back to back.
    vecs.push_back(mk("rr_idle0",   2'b11, 2'b11, FA, FA, L, L, H, L, 32'h5555_AAAA, L, L, L, '0, '0,  2'b00, '0, L));
    vecs.push_back(mk("rr_setup0",  2'b11, 2'b11, FA, FA, L, L, H, L, 32'h5555_AAAA, H, L, H, FA, WD0, 2'b00, '0, L));
    vecs.push_back(mk("rr_access0", 2'b11, 2'b11, FA, FA, L, L, H, L, 32'h5555_AAAA, H, H, H, FA, WD0, 2'b01, '0, L));
    vecs.push_back(mk("rr_idle1",   2'b11, 2'b11, FA, FA, L, L, H, L, 32'h5555_AAAA, L, L, H, FA, WD0, 2'b00, '0, L));
    vecs.push_back(mk("rr_setup1",  2'b11, 2'b11, FA, FA, L, L, H, L, 32'h5555_AAAA, H, L, H, FA, WD1, 2'b00, '0, L));
    vecs.push_back(mk("rr_access1", 2'b11, 2'b11, FA, FA, L, L, H, L, 32'h5555_AAAA, H, H, H, FA, WD1, 2'b10, '0, L));
    vecs.push_back(mk("rr_idle2",   2'b11, 2'b11, FA, FA, L, L, H, L, 32'h5555_AAAA, L, L, H, FA, WD1, 2'b00, '0, L));
    vecs.push_back(mk("rr_setup2",  2'b11, 2'b11, FA, FA, L, L, H, L, 32'h5555_AAAA, H, L, H, FA, WD0, 2'b00, '0, L));
    vecs.push_back(mk("rr_access2", 2'b11, 2'b11, FA, FA, L, L, H, L, 32'h5555_AAAA, H, H, H, FA, WD0, 2'b01, '0, L));
    vecs.push_back(mk("rr_release", 2'b00, 2'b11, FA, FA, L, L, H, L, 32'h5555_AAAA, L, L, H, FA, WD0, 2'b00, '0, L));
    // Requester 0 writes 0x2 to register 0x0; write data never leaks onto rdata.
    vecs.push_back(mk("w_idle",   2'b01, 2'b01, '0, '0, L, L, H, L, 32'hDEAD_BEEF, L, L, H, FA, WD0, 2'b00, '0, L));
    vecs.push_back(mk("w_setup",  2'b01, 2'b01, '0, '0, L, L, H, L, 32'hDEAD_BEEF, H, L, H, '0, WD0, 2'b00, '0, L));
    vecs.push_back(mk("w_access", 2'b01, 2'b01, '0, '0, L, L, H, L, 32'hDEAD_BEEF, H, H, H, '0, WD0, 2'b01, '0, L));
    vecs.push_back(mk("w_after",  2'b00, 2'b01, '0, '0, L, L, H, L, 32'hDEAD_BEEF, L, L, H, '0, WD0, 2'b00, '0, L));
    // Requester 1 FIFO read blocked by empty; requester 0 register read served first.
    vecs.push_back(mk("rd_idle",     2'b11, 2'b00, '0, FA, L, H, H, L, 32'h1234_5678, L, L, H, '0, WD0, 2'b00, '0, L));
    vecs.push_back(mk("rd_setup",    2'b11, 2'b00, '0, FA, L, H, H, L, 32'h1234_5678, H, L, L, '0, WD0, 2'b00, '0, L));
    vecs.push_back(mk("rd_access",   2'b11, 2'b00, '0, FA, L, H, H, L, 32'h1234_5678, H, H, L, '0, WD0, 2'b01, 32'h1234_5678, L));
    vecs.push_back(mk("rd_blocked0", 2'b10, 2'b00, '0, FA, L, H, H, L, 32'h1234_5678, L, L, L, '0, WD0, 2'b00, '0, L));
    vecs.push_back(mk("rd_blocked1", 2'b10, 2'b00, '0, FA, L, H, H, L, 32'h1234_5678, L, L, L, '0, WD0, 2'b00, '0, L));
    vecs.push_back(mk("rd_unblock",  2'b10, 2'b00, '0, FA, L, L, H, L, 32'h1234_5678, L, L, L, '0, WD0, 2'b00, '0, L));
    vecs.push_back(mk("rd_setup1",   2'b10, 2'b00, '0, FA, L, L, H, L, 32'h1234_5678, H, L, L, FA, WD1, 2'b00, '0, L));
    vecs.push_back(mk("rd_wait",     2'b10, 2'b00, '0, FA, L, L, L, L, 32'h1234_5678, H, H, L, FA, WD1, 2'b00, '0, L));
    vecs.push_back(mk("rd_access1",  2'b10, 2'b00, '0, FA, L, L, H, L, 32'hCAFE_F00D, H, H, L, FA, WD1, 2'b10, 32'hCAFE_F00D, L));
    vecs.push_back(mk("rd_after",    2'b00, 2'b00, '0, FA, L, L, H, L, 32'hCAFE_F00D, L, L, L, FA, WD1, 2'b00, '0, L));
    // Slave error on a write to 0x100; requester drops req during SETUP and still gets done.
    vecs.push_back(mk("err_idle",       2'b10, 2'b10, '0, RA, L, L, H, H, 32'hFFFF_FFFF, L, L, L, FA, WD1, 2'b00, '0, L));
    vecs.push_back(mk("err_setup_drop", 2'b00, 2'b10, '0, RA, L, L, H, H, 32'hFFFF_FFFF, H, L, H, RA, WD1, 2'b00, '0, L));
    vecs.push_back(mk("err_access",     2'b00, 2'b10, '0, RA, L, L, H, H, 32'hFFFF_FFFF, H, H, H, RA, WD1, 2'b10, '0, H));
    vecs.push_back(mk("err_after",      2'b00, 2'b10, '0, RA, L, L, H, H, 32'hFFFF_FFFF, L, L, H, RA, WD1, 2'b00, '0, L));
    // FIFO write held off by full while the register write from requester 1 proceeds.
    vecs.push_back(mk("full_idle",    2'b11, 2'b11, FA, '0, H, L, H, L, '0, L, L, H, RA, WD1, 2'b00, '0, L));
    vecs.push_back(mk("full_setup",   2'b11, 2'b11, FA, '0, H, L, H, L, '0, H, L, H, '0, WD1, 2'b00, '0, L));
    vecs.push_back(mk("full_access",  2'b11, 2'b11, FA, '0, H, L, H, L, '0, H, H, H, '0, WD1, 2'b10, '0, L));
    vecs.push_back(mk("full_pending", 2'b01, 2'b11, FA, '0, H, L, H, L, '0, L, L, H, '0, WD1, 2'b00, '0, L));
    vecs.push_back(mk("full_still",   2'b01, 2'b11, FA, '0, H, L, H, L, '0, L, L, H, '0, WD1, 2'b00, '0, L));
    vecs.push_back(mk("full_clear",   2'b01, 2'b11, FA, '0, L, L, H, L, '0, L, L, H, '0, WD1, 2'b00, '0, L));
    vecs.push_back(mk("full_setup0",  2'b01, 2'b11, FA, '0, L, L, H, L, '0, H, L, H, FA, WD0, 2'b00, '0, L));
    vecs.push_back(mk("full_access0", 2'b01, 2'b11, FA, '0, L, L, H, L, '0, H, H, H, FA, WD0, 2'b01, '0, L));
    vecs.push_back(mk("full_end",     2'b00, 2'b11, FA, '0, L, L, H, L, '0, L, L, H, FA, WD0, 2'b00, '0, L));

    PRESETn        = 1'b0;
    req_i          = 2'b11;
    req_write_i    = 2'b11;
    req_addr_i[0]  = FA;
    req_addr_i[1]  = FA;
    req_wdata_i[0] = WD0;
    req_wdata_i[1] = WD1;
    req_strb_i[0]  = 4'hF;
    req_strb_i[1]  = 4'h3;
    PREADY         = 1'b1;
    PRDATA         = 32'h7777_7777;
    PSLVERR        = 1'b1;
    fifo_full_i    = 1'b0;
    fifo_empty_i   = 1'b0;

    #2;
    check_output("reset_all", 128'({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, done_o, rdata_o, err_o}), 128'(0));
    @(negedge PCLK);
    @(negedge PCLK);
    #1;
    check_output("reset_held", 128'({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, done_o, rdata_o, err_o}), 128'(0));
    req_i   = 2'b00;
    PSLVERR = 1'b0;
    PRESETn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge PCLK);
      apply_stimulus(vecs[i]);
      #1;
      check_output(vecs[i].name,
                   128'({PSEL, PENABLE, PWRITE, PADDR, PWDATA, done_o, rdata_o, err_o}),
                   128'({vecs[i].psel, vecs[i].pen, vecs[i].pw, vecs[i].paddr, vecs[i].pwdata,
                         vecs[i].done, vecs[i].rdata, vecs[i].err}));
    end

    // Reset in ACCESS: requester 0 is mid-transfer (pointer now favours 1) when PRESETn drops.
    @(negedge PCLK);
    req_i         = 2'b01;
    req_write_i   = 2'b00;
    req_addr_i[0] = 32'h0000_0004;
    req_addr_i[1] = 32'h0000_0008;
    fifo_full_i   = 1'b0;
    fifo_empty_i  = 1'b0;
    PREADY        = 1'b0;
    PSLVERR       = 1'b0;
    PRDATA        = 32'h0BAD_CAFE;
    @(negedge PCLK);
    #1;
    check_output("hs_setup", 128'({PSEL, PENABLE, PADDR, PSTRB, PPROT}), 128'({H, L, 32'h0000_0004, 4'hF, 3'b000}));
    @(negedge PCLK);
    #1;
    check_output("hs_access_wait", 128'({PSEL, PENABLE, done_o, err_o}), 128'({H, H, 2'b00, L}));
    #1;
    PRESETn = 1'b0;
    #1;
    check_output("hs_async_reset", 128'({PSEL, PENABLE, PWRITE, PADDR, PSTRB, done_o, err_o}), 128'(0));
    @(negedge PCLK);
    PRESETn     = 1'b1;
    req_i       = 2'b11;
    req_write_i = 2'b00;
    PREADY      = 1'b1;
    #1;
    check_output("hs_no_done", 128'({PSEL, done_o, rdata_o}), 128'(0));
    @(negedge PCLK);
    #1;
    check_output("hs_prio_req0", 128'({PSEL, PENABLE, PWRITE, PADDR, PSTRB}), 128'({H, L, L, 32'h0000_0004, 4'hF}));
    @(negedge PCLK);
    #1;
    check_output("hs_done_req0", 128'({done_o, rdata_o, err_o}), 128'({2'b01, 32'h0BAD_CAFE, L}));
    req_i = 2'b10;
    @(negedge PCLK);
    #1;
    check_output("hs_then_req1", 128'({PSEL, done_o}), 128'({L, 2'b00}));
    @(negedge PCLK);
    #1;
    check_output("hs_setup_req1", 128'({PSEL, PENABLE, PADDR, PSTRB}), 128'({H, L, 32'h0000_0008, 4'h3}));
    req_i = 2'b00;
    @(negedge PCLK);
    #1;
    check_output("hs_done_req1", 128'({done_o, rdata_o}), 128'({2'b10, 32'h0BAD_CAFE}));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/fifo_apb_arbiter.md
FIFO_APB_ARBITER -- requirements
Module: fifo_apb_arbiter

Interface
REQ-001 Parameter NREQ, 2, number of requesters sharing the FIFO APB slave (fixed at 2).
REQ-002 Parameter TIMEOUT, 16, ACCESS-phase wait limit in PCLK cycles (used only with the timeout feature).
REQ-003 PCLK  input  1  single clock; all logic is rising-edge.
REQ-004 PRESETn  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  [1:0]  per-requester transfer request, held until done.
REQ-006 req_write_i  input  [1:0]  per-requester direction: 1 = write, 0 = read.
REQ-007 req_addr_i  input  [1:0][31:0]  per-requester address; bit 31 = 1 selects FIFO data, 0 selects a register.
REQ-008 req_wdata_i  input  [1:0][31:0]  per-requester write data.
REQ-009 req_strb_i  input  [1:0][3:0]  per-requester byte strobes.
REQ-010 done_o  output  [1:0]  one-cycle completion pulse to the granted requester.
REQ-011 rdata_o  output  32  read data, valid while done_o is high.
REQ-012 err_o  output  1  slave error or timeout, valid while done_o is high.
REQ-013 PSEL, PENABLE, PWRITE (1 each), PADDR, PWDATA (32 each), PSTRB (4), PPROT (3)  outputs  APB master request.
REQ-014 PREADY (1), PRDATA (32), PSLVERR (1)  inputs  APB completer response.
REQ-015 fifo_full_i, fifo_empty_i  input  1 each  FIFO status flags.

Function
REQ-016 FSM states IDLE, SETUP, ACCESS; IDLE->SETUP on grant; SETUP->ACCESS always; ACCESS->IDLE on PREADY=1 (or on timeout).
REQ-017 A requester is eligible when req_i=1, excluding a FIFO-data write while fifo_full_i=1 and a FIFO-data read while fifo_empty_i=1; register accesses are always eligible.
REQ-018 In IDLE, arbitration is round-robin among eligible requesters; the priority pointer moves to the requester after the one granted; at reset requester 0 has priority.
REQ-019 On grant, address, direction, wdata and strobes are latched; PSEL=1, PENABLE=0 in the next cycle (SETUP), then PENABLE=1 (ACCESS).
REQ-020 APB outputs are registered and remain stable from SETUP through ACCESS; PPROT is constant 3'b000.
REQ-021 In the ACCESS cycle with PREADY=1: done_o[g]=1, rdata_o=PRDATA (zero for writes), err_o=PSLVERR; PSEL=PENABLE=0 in the following cycle.
REQ-022 At least one IDLE cycle separates transfers; minimum request-to-done latency is 3 cycles.
REQ-023 Ineligible requests remain pending without a done pulse until the flag clears; an eligible requester is never starved by them.
REQ-024 A requester deasserting req_i mid-transfer does not abort it; done_o still pulses.

Reset
REQ-025 PRESETn low forces IDLE, PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, PSTRB=0, done_o=0, rdata_o=0, err_o=0, and the priority pointer to 0, immediately and asynchronously.
REQ-026 Reset during SETUP or ACCESS abandons the transfer without a done pulse.

Configuration
REQ-027 With APB_ARB_TIMEOUT_EN defined, a counter runs in ACCESS; after TIMEOUT consecutive cycles with PREADY=0 the arbiter pulses done_o with err_o=1, drops PSEL/PENABLE and returns to IDLE.
REQ-028 With APB_ARB_TIMEOUT_EN undefined, ACCESS waits for PREADY indefinitely and no counter is instantiated.

Structure
REQ-029 A shared package fifo_apb_pkg holds the state enum, FIFO_DATA_BIT=31, register offsets (DEPTH_REG=0x0), and the default TIMEOUT.
REQ-030 Arbitration is one sub-module, rr_arb2 (eligible vector in, one-hot grant out, pointer update on accept).

Verification
REQ-031 Requester 0 writes 0x2 to address 0x0 with both FIFO flags clear -> PSEL at +1, PENABLE at +2, done_o=01 at +2, err_o=0.
REQ-032 Both request FIFO writes (0x8000_0000) continuously, FIFO never full -> grants alternate 0,1,0,1 with done pulses every 3 cycles.
REQ-033 Requester 1 reads 0x8000_0000 while fifo_empty_i=1 and requester 0 reads 0x0 -> only requester 0 is served; requester 1 is served after fifo_empty_i falls.
REQ-034 Access to 0x0000_0100 with PSLVERR=1 -> done pulse with err_o=1, rdata_o=0.
REQ-035 With APB_ARB_TIMEOUT_EN and TIMEOUT=4, PREADY held 0 -> err_o=1 with done after 4 ACCESS cycles, then IDLE.
REQ-036 PRESETn pulsed low during ACCESS -> PSEL=0 immediately, no done pulse, requester 0 has priority afterwards.
